ex_alu_fwd: RTL and testbench

- Execute-stage datapath core of the 5-stage MIPS pipeline.
- Resolves RAW hazards by forwarding MEM/WB write-back values onto the rs/rt operands, selects the ALU B operand, and evaluates a 16-op ALU with a separate address adder.
- Registers the result into the EX/MEM boundary, with a flush input.

---
 rtl/ex_pkg.sv | 31 +++
 rtl/ex_fwd_mux.sv | 31 +++
 rtl/ex_alu_fwd.sv | 128 ++++++++++++
 tb/tb_ex_alu_fwd.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes and the
// write-back bus format used by the MEM and WB forwarding paths.
package ex_pkg;

  localparam int EX_DW = 32;
  localparam int EX_RW = 5;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_SLLV  = 4'd11;
  localparam logic [3:0] ALU_SRLV  = 4'd12;
  localparam logic [3:0] ALU_SRAV  = 4'd13;
  localparam logic [3:0] ALU_LUI   = 4'd14;
  localparam logic [3:0] ALU_PASSB = 4'd15;

  typedef struct packed {
    logic             we;
    logic [EX_RW-1:0] waddr;
    logic [EX_DW-1:0] wdata;
  } back_bus_t;

endpackage

// File: rtl/ex_fwd_mux.sv
// Single-operand forwarding selector: MEM beats WB, register 0 never forwards.
module ex_fwd_mux
  import ex_pkg::*;
(
  input  logic             [EX_RW-1:0] idx_i,
  input  logic             [EX_DW-1:0] rd_i,
  input  back_bus_t                    mem_b_i,
  input  back_bus_t                    wb_b_i,
  input  logic                         use_mem_i,
  input  logic                         use_wb_i,
  output logic             [EX_DW-1:0] fwd_o
);

  logic nz;
  logic mem_hit;
  logic wb_hit;

  assign nz      = (idx_i != '0);
  assign mem_hit = use_mem_i && mem_b_i.we && (mem_b_i.waddr == idx_i) && nz;
  assign wb_hit  = use_wb_i && wb_b_i.we && (wb_b_i.waddr == idx_i) && nz;

  always_comb begin
    fwd_o = rd_i;
    if (mem_hit) begin
      fwd_o = mem_b_i.wdata;
    end else if (wb_hit) begin
      fwd_o = wb_b_i.wdata;
    end
  end

endmodule

// File: rtl/ex_alu_fwd.sv
// Execute stage: operand forwarding, 16-op ALU, address adder and the
// EX/MEM register boundary with flush.
module ex_alu_fwd
  import ex_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [37:0]   mem_back,
  input  logic [37:0]   wb_back,
  input  logic          use_mem_back,
  input  logic          use_wb_back,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic [DW-1:0] ext_b,
  input  logic          alu_src,
  input  logic [3:0]    aluop,
  input  logic [4:0]    sa,
  output logic [DW-1:0] f_rd1,
  output logic [DW-1:0] f_rd2,
  output logic [DW-1:0] alu_c,
  output logic [DW-1:0] sum,
  output logic          zero,
  output logic [DW-1:0] q_c,
  output logic [DW-1:0] q_rd2,
  output logic          q_zero,
  output logic          q_valid
);

  back_bus_t     mem_b;
  back_bus_t     wb_b;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [4:0]    shamt;

  assign mem_b = mem_back;
  assign wb_b  = wb_back;

  ex_fwd_mux u_fwd_a (
    .idx_i     (rs),
    .rd_i      (rd1),
    .mem_b_i   (mem_b),
    .wb_b_i    (wb_b),
    .use_mem_i (use_mem_back),
    .use_wb_i  (use_wb_back),
    .fwd_o     (f_rd1)
  );

  ex_fwd_mux u_fwd_b (
    .idx_i     (rt),
    .rd_i      (rd2),
    .mem_b_i   (mem_b),
    .wb_b_i    (wb_b),
    .use_mem_i (use_mem_back),
    .use_wb_i  (use_wb_back),
    .fwd_o     (f_rd2)
  );

  assign op_a = f_rd1;
  assign op_b = alu_src ? ext_b : f_rd2;
  assign sum  = op_a + op_b;

  // Variable shifts take their count from the low five bits of A.
  assign shamt = (aluop == ALU_SLLV || aluop == ALU_SRLV || aluop == ALU_SRAV)
               ? op_a[4:0] : sa;

  always_comb begin
    alu_c = '0;
    case (aluop)
      ALU_ADD:   alu_c = op_a + op_b;
      ALU_SUB:   alu_c = op_a - op_b;
      ALU_AND:   alu_c = op_a & op_b;
      ALU_OR:    alu_c = op_a | op_b;
      ALU_XOR:   alu_c = op_a ^ op_b;
      ALU_NOR:   alu_c = ~(op_a | op_b);
      ALU_SLT:   alu_c = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:  alu_c = {{(DW-1){1'b0}}, (op_a < op_b)};
      ALU_SLL,
      ALU_SLLV:  alu_c = op_b << shamt;
      ALU_SRL,
      ALU_SRLV:  alu_c = op_b >> shamt;
      ALU_SRA,
      ALU_SRAV:  alu_c = $signed(op_b) >>> shamt;
      ALU_LUI:   alu_c = {op_b[15:0], 16'h0000};
      ALU_PASSB: alu_c = op_b;
      default:   alu_c = '0;
    endcase
  end

  assign zero = (alu_c == '0);

  // q_valid marks a live result; there is no ready, the MEM stage
  // accepts every cycle. A flushed slot still loads data but is not valid.
  logic [DW-1:0] c_q, c_d;
  logic [DW-1:0] rd2_q, rd2_d;
  logic          zero_q, zero_d;
  logic          valid_q, valid_d;

  assign c_d     = alu_c;
  assign rd2_d   = f_rd2;
  assign zero_d  = zero;
  assign valid_d = ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q     <= '0;
      rd2_q   <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      c_q     <= c_d;
      rd2_q   <= rd2_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign q_c     = c_q;
  assign q_rd2   = rd2_q;
  assign q_zero  = zero_q;
  assign q_valid = valid_q;

endmodule

// File: tb/tb_ex_alu_fwd.sv
// Bench for ex_alu_fwd: directed hazard/ALU cases plus random traffic,
// registered results checked through an expected-value queue.
module tb_ex_alu_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [37:0] mem_back, wb_back;
  logic        use_mem_back, use_wb_back;
  logic [4:0]  rs, rt;
  logic [31:0] rd1, rd2, ext_b;
  logic        alu_src;
  logic [3:0]  aluop;
  logic [4:0]  sa;
  logic [31:0] f_rd1, f_rd2, alu_c, sum, q_c, q_rd2;
  logic        zero, q_zero, q_valid;

  int total = 0;
  int bad   = 0;
  logic [65:0] exp_q[$];

  ex_alu_fwd dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_back(mem_back), .wb_back(wb_back),
    .use_mem_back(use_mem_back), .use_wb_back(use_wb_back),
    .rs(rs), .rt(rt), .rd1(rd1), .rd2(rd2), .ext_b(ext_b),
    .alu_src(alu_src), .aluop(aluop), .sa(sa),
    .f_rd1(f_rd1), .f_rd2(f_rd2), .alu_c(alu_c), .sum(sum), .zero(zero),
    .q_c(q_c), .q_rd2(q_rd2), .q_zero(q_zero), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_model(input logic [4:0] idx, input logic [31:0] rd,
                                            input logic [37:0] mb, input logic [37:0] wb,
                                            input logic um, input logic uw);
    if (idx == 5'd0) return rd;
    if (um && mb[37] && mb[36:32] == idx) return mb[31:0];
    if (uw && wb[37] && wb[36:32] == idx) return wb[31:0];
    return rd;
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] s);
    logic [63:0] ext;
    logic [4:0]  n;
    n = (op >= 4'd11 && op <= 4'd13) ? a[4:0] : s;
    ext = {{32{b[31]}}, b} >> n;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a & ~b;
      4'd6:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      4'd7:  return {31'b0, a < b};
      4'd8, 4'd11:  return b << n;
      4'd9, 4'd12:  return b >> n;
      4'd10, 4'd13: return ext[31:0];
      4'd14: return {b[15:0], 16'h0};
      default: return b;
    endcase
  endfunction

  task automatic clear_inputs();
    flush = 0; mem_back = '0; wb_back = '0; use_mem_back = 0; use_wb_back = 0;
    rs = 0; rt = 0; rd1 = 0; rd2 = 0; ext_b = 0; alu_src = 0; aluop = 0; sa = 0;
  endtask

  // Checks combinational outputs mid-cycle, queues the registered
  // expectation, then compares it one edge later.
  task automatic step();
    logic [31:0] e1, e2, b, ec;
    logic [65:0] ent;
    @(negedge clk);
    e1 = fwd_model(rs, rd1, mem_back, wb_back, use_mem_back, use_wb_back);
    e2 = fwd_model(rt, rd2, mem_back, wb_back, use_mem_back, use_wb_back);
    b  = alu_src ? ext_b : e2;
    ec = alu_model(aluop, e1, b, sa);
    check("f_rd1", f_rd1, e1);
    check("f_rd2", f_rd2, e2);
    check("alu_c", alu_c, ec);
    check("sum", sum, e1 + b);
    check("zero", {31'b0, zero}, {31'b0, ec == 32'd0});
    exp_q.push_back({~flush, ec == 32'd0, e2, ec});
    @(posedge clk); #1;
    ent = exp_q.pop_front();
    check("q_c", q_c, ent[31:0]);
    check("q_rd2", q_rd2, ent[63:32]);
    check("q_zero", {31'b0, q_zero}, {31'b0, ent[64]});
    check("q_valid", {31'b0, q_valid}, {31'b0, ent[65]});
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    #2;
    check("rst_q_c", q_c, 32'd0);
    check("rst_q_rd2", q_rd2, 32'd0);
    check("rst_q_valid", {31'b0, q_valid}, 32'd0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    // no hazard
    rs = 3; rd1 = 10; rt = 4; rd2 = 7; aluop = 4'd0;
    #1;
    check("nh_alu_c", alu_c, 32'd17);
    check("nh_sum", sum, 32'd17);
    check("nh_zero", {31'b0, zero}, 32'd0);
    step();
    check("nh_q_c", q_c, 32'd17);
    check("nh_q_valid", {31'b0, q_valid}, 32'd1);

    // dual forward
    mem_back = {1'b1, 5'd3, 32'd100}; wb_back = {1'b1, 5'd3, 32'd200};
    use_mem_back = 1; use_wb_back = 1;
    #1; check("fwd_mem_wins", f_rd1, 32'd100);
    step();
    use_mem_back = 0;
    #1; check("fwd_wb", f_rd1, 32'd200);
    step();
    use_mem_back = 1; rs = 0; mem_back = {1'b1, 5'd0, 32'd100}; wb_back = {1'b1, 5'd0, 32'd200};
    #1; check("fwd_r0", f_rd1, 32'd10);
    step();

    // signedness
    clear_inputs();
    rs = 1; rd1 = 32'hFFFFFFFF; alu_src = 1; ext_b = 32'd1; aluop = 4'd6;
    #1; check("slt", alu_c, 32'd1);
    step();
    aluop = 4'd7;
    #1; check("sltu", alu_c, 32'd0);
    step();
    ext_b = 32'h80000000; sa = 5'd4; aluop = 4'd10;
    #1; check("sra", alu_c, 32'hF8000000);
    step();

    // immediate path
    rd1 = 32'h1000; ext_b = 32'h0000FFFC; aluop = 4'd14;
    #1;
    check("lui", alu_c, 32'hFFFC0000);
    check("lui_sum", sum, 32'h00010FFC);
    step();

    // SUB of equal operands
    clear_inputs();
    rs = 2; rt = 6; rd1 = 5; rd2 = 5; aluop = 4'd1;
    #1;
    check("sub_c", alu_c, 32'd0);
    check("sub_zero", {31'b0, zero}, 32'd1);
    step();
    check("sub_q_zero", {31'b0, q_zero}, 32'd1);

    // flush
    flush = 1;
    step();
    check("flush_valid", {31'b0, q_valid}, 32'd0);
    flush = 0;

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rs = 5'($urandom_range(0, 4)); rt = 5'($urandom_range(0, 4));
      rd1 = $urandom; rd2 = $urandom;
      ext_b = ($urandom_range(0, 3) == 0) ? rd1 : $urandom;
      mem_back = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), 32'($urandom)};
      wb_back  = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), 32'($urandom)};
      use_mem_back = 1'($urandom_range(0, 1)); use_wb_back = 1'($urandom_range(0, 1));
      alu_src = 1'($urandom_range(0, 1)); aluop = 4'($urandom_range(0, 15));
      sa = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 7) == 0);
      step();
    end

    // async reset mid-cycle, then flush+reset together
    clear_inputs();
    rs = 1; rd1 = 32'h1234; aluop = 4'd15; alu_src = 1; ext_b = 32'hABCD;
    step();
    #2; rst = 0; #1;
    check("arst_q_c", q_c, 32'd0);
    check("arst_q_rd2", q_rd2, 32'd0);
    check("arst_q_zero", {31'b0, q_zero}, 32'd0);
    check("arst_q_valid", {31'b0, q_valid}, 32'd0);
    flush = 1;
    @(posedge clk); #1;
    check("rstflush_valid", {31'b0, q_valid}, 32'd0);
    check("rstflush_q_c", q_c, 32'd0);
    @(negedge clk); rst = 1; flush = 0;
    @(posedge clk); #1;
    step();
    check("post_rst_q_c", q_c, 32'h0000ABCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
